// File: rtl/spi_mem_loader.sv
// spi_mem_loader: serial frame loader for the instruction and data caches.
// A frame is {cmd, addr, data}, sent MSB first with one bit per clk cycle
// while one chip select is low. Writes go out as a one-cycle strobe. Reads
// from the data cache are returned on miso during the data slots.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cs_i_n, cs_d_n   instruction / data cache chip selects (active low)
//   mosi, miso       serial in / serial read data out
//   proc_en          processor running: frames are refused or aborted
//   rd_addr_o        data-cache read address
//   rd_data_i        data-cache combinational read data
//   wr_en_o          write strobe, with wr_tgt_o / wr_addr_o / wr_data_o
//   busy_o           high whenever the loader is not idle
//   frame_err_o      one-cycle pulse for each discarded frame
//   wr_cnt_o         committed write counter (wraps)
module spi_mem_loader #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned D_DEPTH = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_i_n,
  input  logic              cs_d_n,
  input  logic              mosi,
  input  logic              proc_en,
  output logic              miso,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              wr_en_o,
  output logic              wr_tgt_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned PAY_W   = ADDR_W + DATA_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned SLOT0   = 1 + ADDR_W;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHIFT   = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;
  localparam logic [1:0] WAIT_CS = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [PAY_W-2:0]  sr;
  logic              cmd_rd;
  logic [DATA_W-1:0] out_sr;

  logic              sel_ok;
  logic              frame_start;
  logic              idle_clash;
  logic              shift_en;
  logic              frame_abort;
  logic              frame_done;
  logic [PAY_W-1:0]  frame_nxt;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_data;
  logic              range_bad;
  logic              commit_wr;
  logic              commit_bad;
  logic              rd_active;
  logic              slot0;
  logic              in_slots;
  logic              addr_last;

  // Next state and per-cycle frame events
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    idle_clash  = 1'b0;
    shift_en    = 1'b0;
    frame_abort = 1'b0;
    frame_done  = 1'b0;
    // Transfer continues only while the latched select alone is low
    sel_ok = wr_tgt_o ? (!cs_d_n && cs_i_n && !proc_en)
                      : (!cs_i_n && cs_d_n && !proc_en);
    case (state)
      IDLE: begin
        if (!proc_en) begin
          if (!cs_i_n && !cs_d_n) begin
            idle_clash = 1'b1;
            state_nxt  = WAIT_CS;
          end else if (cs_i_n != cs_d_n) begin
            frame_start = 1'b1;
            state_nxt   = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (sel_ok) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
            frame_done = 1'b1;
            state_nxt  = COMMIT;
          end
        end else begin
          frame_abort = 1'b1;
          state_nxt   = WAIT_CS;
        end
      end
      COMMIT:  state_nxt = WAIT_CS;
      WAIT_CS: if (cs_i_n && cs_d_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame decode: fields as they will stand once this cycle's bit is in
  always_comb begin
    frame_nxt  = {sr, mosi};
    nxt_addr   = frame_nxt[PAY_W-1 -: ADDR_W];
    nxt_data   = frame_nxt[DATA_W-1:0];
    range_bad  = wr_tgt_o && (32'(nxt_addr) >= D_DEPTH);
    commit_wr  = frame_done && !cmd_rd && !range_bad;
    commit_bad = frame_done && !cmd_rd && range_bad;
    rd_active  = (state == SHIFT) && cmd_rd && wr_tgt_o;
    addr_last  = rd_active && shift_en && (bit_cnt == BIT_W'(SLOT0 - 1));
    slot0      = rd_active && sel_ok && (bit_cnt == BIT_W'(SLOT0));
    in_slots   = rd_active && sel_ok && (bit_cnt >= BIT_W'(SLOT0));
  end

  // Slot 0 comes straight from the cache; later slots from the shift register
  always_comb begin
    miso = 1'b0;
    if (slot0)         miso = rd_data_i[DATA_W-1];
    else if (in_slots) miso = out_sr[DATA_W-1];
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      sr          <= '0;
      cmd_rd      <= 1'b0;
      out_sr      <= '0;
      rd_addr_o   <= '0;
      wr_en_o     <= 1'b0;
      wr_tgt_o    <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
      wr_cnt_o    <= '0;
    end else begin
      state       <= state_nxt;
      busy_o      <= (state_nxt != IDLE);
      frame_err_o <= idle_clash | frame_abort | commit_bad;
      wr_en_o     <= commit_wr;

      if (frame_start) begin
        sr       <= '0;
        cmd_rd   <= mosi;
        wr_tgt_o <= cs_i_n;
        bit_cnt  <= BIT_W'(1);
      end else if (shift_en) begin
        sr      <= frame_nxt[PAY_W-2:0];
        bit_cnt <= bit_cnt + BIT_W'(1);
      end

      if (commit_wr) begin
        wr_addr_o <= nxt_addr;
        wr_data_o <= nxt_data;
      end

      if (addr_last) rd_addr_o <= frame_nxt[ADDR_W-1:0];

      if (slot0)         out_sr <= {rd_data_i[DATA_W-2:0], 1'b0};
      else if (in_slots) out_sr <= {out_sr[DATA_W-2:0], 1'b0};

      // Count lands on the edge that ends the strobe cycle
      if ((state == COMMIT) && wr_en_o) wr_cnt_o <= wr_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_spi_mem_loader.sv
// Testbench for spi_mem_loader: randomized and directed frames, with
// expected writes, error pulses and read bits queued by the driver and
// consumed by an independent monitor.
module tb_spi_mem_loader;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned D_DEPTH = 15;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cs_i_n = 1'b1;
  logic              cs_d_n = 1'b1;
  logic              mosi = 1'b0;
  logic              proc_en = 1'b0;
  logic              miso;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_i;
  logic              wr_en_o;
  logic              wr_tgt_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              busy_o;
  logic              frame_err_o;
  logic [CNT_W-1:0]  wr_cnt_o;

  spi_mem_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .D_DEPTH(D_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .cs_i_n(cs_i_n), .cs_d_n(cs_d_n), .mosi(mosi),
    .proc_en(proc_en), .miso(miso), .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i), .wr_en_o(wr_en_o), .wr_tgt_o(wr_tgt_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o),
    .frame_err_o(frame_err_o), .wr_cnt_o(wr_cnt_o)
  );

  always #5 clk = ~clk;

  // Data-cache contents seen on the read port
  logic [DATA_W-1:0] dmem [0:15];
  always_comb rd_data_i = dmem[rd_addr_o];

  typedef struct packed {
    logic              tgt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
  } wr_t;

  wr_t              wr_q[$];
  logic             miso_q[$];
  int               err_pending = 0;
  logic             rd_slot = 1'b0;
  logic [CNT_W-1:0] model_cnt = '0;
  int               errors = 0;
  int               checks = 0;
  wr_t              mon_e;
  logic             mon_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents an event
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_o) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wr: tgt=%0d addr=%0d data=0x%0h at %0t",
                   wr_tgt_o, wr_addr_o, wr_data_o, $time);
        end else begin
          mon_e = wr_q.pop_front();
          chk("wr_event", 32'({wr_tgt_o, wr_addr_o, wr_data_o, wr_cnt_o}), 32'(mon_e));
        end
      end
      if (frame_err_o) begin
        checks++;
        if (err_pending == 0) begin
          errors++;
          $display("FAIL unexpected_frame_err: got 1 expected 0 at %0t", $time);
        end else begin
          err_pending--;
        end
      end
      if (rd_slot) begin
        if (miso_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL miso_q_underflow: got %0d expected none at %0t", miso, $time);
        end else begin
          mon_b = miso_q.pop_front();
          chk("miso_slot", 32'(miso), 32'(mon_b));
        end
      end else begin
        chk("miso_idle", 32'(miso), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    cs_i_n  = 1'b1;
    cs_d_n  = 1'b1;
    rd_slot = 1'b0;
    tick();
    tick();
  endtask

  // Drive one frame; abort_at < 0 means complete it
  task automatic send_frame(input logic tgt, input logic rd, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data, input int abort_at,
                            input int abort_kind, input int hold_extra);
    logic [FRAME_W-1:0] bits;
    bit aborted;
    bits = {rd, addr, data};
    aborted = 1'b0;
    if (abort_at < 0 && !rd) begin
      if (tgt && (32'(addr) >= D_DEPTH)) err_pending++;
      else begin
        wr_q.push_back({tgt, addr, data, model_cnt});
        model_cnt++;
      end
    end
    for (int i = 0; i < int'(FRAME_W); i++) begin
      if (i == abort_at) begin
        case (abort_kind)
          0:       if (tgt) cs_d_n = 1'b1; else cs_i_n = 1'b1;
          1:       if (tgt) cs_i_n = 1'b0; else cs_d_n = 1'b0;
          default: proc_en = 1'b1;
        endcase
        rd_slot = 1'b0;
        err_pending++;
        aborted = 1'b1;
        tick();
        break;
      end
      if (i == 1) chk("busy_rise", 32'(busy_o), 32'd1);
      if (tgt) cs_d_n = 1'b0; else cs_i_n = 1'b0;
      if (rd && i >= int'(1 + ADDR_W)) mosi = 1'($urandom_range(0, 1));
      else mosi = bits[FRAME_W-1-i];
      if (rd && tgt && i >= int'(1 + ADDR_W)) begin
        rd_slot = 1'b1;
        miso_q.push_back(dmem[addr][DATA_W-1-(i-1-int'(ADDR_W))]);
      end else begin
        rd_slot = 1'b0;
      end
      tick();
    end
    rd_slot = 1'b0;
    if (!aborted) repeat (hold_extra) tick();
    proc_en = 1'b0;
    idle_gap();
    chk("busy_after_frame", 32'(busy_o), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
    chk({tag, "_err"}, 32'(frame_err_o), 32'd0);
    chk({tag, "_miso"}, 32'(miso), 32'd0);
    chk({tag, "_cnt"}, 32'(wr_cnt_o), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr_o), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data_o), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr_o), 32'd0);
    chk({tag, "_wr_tgt"}, 32'(wr_tgt_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME_W-1:0] rbits;
    logic t;
    for (int i = 0; i < 16; i++) dmem[i] = DATA_W'($urandom);
    dmem[5] = 8'hC3;

    rst = 1'b1;
    tick(); tick(); tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // Instruction-cache write
    send_frame(1'b0, 1'b0, 4'd3, 8'hA5, -1, 0, 0);
    chk("cnt_first", 32'(wr_cnt_o), 32'd1);

    // Data-cache range edge
    send_frame(1'b1, 1'b0, 4'd14, 8'h7E, -1, 0, 0);
    send_frame(1'b1, 1'b0, 4'd15, 8'h11, -1, 0, 0);
    chk("cnt_range", 32'(wr_cnt_o), 32'd2);

    // Readback and instruction-target read
    send_frame(1'b1, 1'b1, 4'd5, 8'h00, -1, 0, 0);
    send_frame(1'b0, 1'b1, 4'd5, 8'hFF, -1, 0, 0);

    // Aborts
    send_frame(1'b1, 1'b0, 4'd2, 8'h55, 6, 0, 0);
    send_frame(1'b0, 1'b0, 4'd9, 8'h66, 9, 2, 0);
    send_frame(1'b1, 1'b1, 4'd5, 8'h00, 9, 1, 0);
    chk("cnt_aborts", 32'(wr_cnt_o), 32'd2);

    // Both selects low while idle
    cs_i_n = 1'b0; cs_d_n = 1'b0; mosi = 1'b1;
    err_pending++;
    tick(); tick();
    chk("clash_busy", 32'(busy_o), 32'd1);
    tick(); tick();
    idle_gap();
    chk("clash_idle", 32'(busy_o), 32'd0);

    // proc_en refuses a frame start
    proc_en = 1'b1; cs_i_n = 1'b0;
    tick(); tick(); tick();
    chk("proc_en_refuse", 32'(busy_o), 32'd0);
    cs_i_n = 1'b1; tick();
    proc_en = 1'b0; tick();

    // Select held past the end of a frame
    send_frame(1'b0, 1'b0, 4'd7, 8'h3C, -1, 0, 5);
    chk("cnt_hold", 32'(wr_cnt_o), 32'd3);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      t = 1'($urandom_range(0, 1));
      send_frame(t, 1'($urandom_range(0, 2) == 0), ADDR_W'($urandom), DATA_W'($urandom),
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, FRAME_W - 1)) : -1,
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    chk("cnt_random", 32'(wr_cnt_o), 32'(model_cnt));

    // Reset in the middle of a write frame
    rbits = {1'b0, 4'd8, 8'h99};
    for (int i = 0; i < 7; i++) begin
      cs_i_n = 1'b0;
      mosi = rbits[FRAME_W-1-i];
      tick();
    end
    rst = 1'b1;
    tick(); tick();
    cs_i_n = 1'b1;
    tick();
    check_reset_values("midreset");
    rst = 1'b0;
    model_cnt = '0;
    tick();
    send_frame(1'b0, 1'b0, 4'd8, 8'h99, -1, 0, 0);
    chk("cnt_after_reset", 32'(wr_cnt_o), 32'd1);

    // Counter wrap
    for (int n = 0; n < 254; n++) begin
      t = 1'($urandom_range(0, 1));
      send_frame(t, 1'b0, t ? ADDR_W'($urandom_range(0, D_DEPTH - 1)) : ADDR_W'($urandom),
                 DATA_W'($urandom), -1, 0, 0);
    end
    chk("cnt_255", 32'(wr_cnt_o), 32'd255);
    send_frame(1'b1, 1'b0, 4'd0, 8'h01, -1, 0, 0);
    chk("cnt_wrap", 32'(wr_cnt_o), 32'd0);

    tick(); tick();
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("err_drained", 32'(err_pending), 32'd0);
    chk("miso_q_drained", 32'(miso_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_mem_loader.md
# spi_mem_loader

Parametrised serial loader that replaces the fixed 12-bit shift buffer and RECV/WRITE sequencing in front of the processor's instruction and data caches. It receives framed commands from an external master clocked by `clk`, writes 8-bit words into either cache, reads data-cache words back over `miso`, and reports framing and range errors. It sits between the `uio` pins and the cache write ports, and is inactive while the master holds the processor in execution.

## Interface
Parameters:
- `DATA_W`, 8, word width of both caches and of the frame data field
- `ADDR_W`, 4, frame address field width; the instruction cache depth is 2**ADDR_W
- `D_DEPTH`, 15, number of data-cache entries; valid data addresses are 0..D_DEPTH-1
- `CNT_W`, 8, width of the committed-write counter

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `cs_i_n`  in  1  instruction-cache chip select, active low
- `cs_d_n`  in  1  data-cache chip select, active low
- `mosi`  in  1  serial data in, MSB first, sampled on the rising edge of `clk`
- `proc_en`  in  1  master has the processor executing; frames are refused or aborted
- `miso`  out  1  serial read data
- `rd_addr_o`  out  ADDR_W  data-cache read address
- `rd_data_i`  in  DATA_W  data-cache combinational read data
- `wr_en_o`  out  1  one-cycle write strobe
- `wr_tgt_o`  out  1  write target: 0 = instruction cache, 1 = data cache
- `wr_addr_o`  out  ADDR_W  write address
- `wr_data_o`  out  DATA_W  write data
- `busy_o`  out  1  high in every state other than IDLE
- `frame_err_o`  out  1  one-cycle pulse when a frame is discarded
- `wr_cnt_o`  out  CNT_W  count of committed writes; wraps modulo 2**CNT_W

## Operation
- Frame layout: `FRAME_W = 1 + ADDR_W + DATA_W` bits, MSB first, in the order cmd (0 = write, 1 = read), addr, data. One bit is transferred per `clk` cycle while the selected chip select is low.
- The state machine has four states: IDLE, SHIFT, COMMIT, WAIT_CS.
- IDLE to SHIFT: `proc_en` is 0 and exactly one chip select is low. The cmd bit is captured in this same cycle, `wr_tgt_o`/target is latched (0 if `cs_i_n` is low), and the bit count is set to 1.
- Both chip selects low while in IDLE: pulse `frame_err_o`, then go to WAIT_CS.
- SHIFT: on each cycle where the latched chip select is still low and the other is high, shift `mosi` in and increment the count. When the count reaches FRAME_W, go to COMMIT.
- SHIFT abort: if the latched chip select rises, the other chip select falls, or `proc_en` rises before the frame completes, pulse `frame_err_o`, discard the frame, and go to WAIT_CS. No write is issued.
- Read command:
  - A read with the instruction-cache target is accepted; its data bits are ignored and `miso` is 0.
  - A read with the data-cache target: `rd_addr_o` equals the address field from the first data slot onward.
  - In data slot 0, `miso` is `rd_data_i[DATA_W-1]` (combinational) and the output shift register loads `rd_data_i << 1`.
  - In slots 1..DATA_W-1, `miso` is the shift register MSB. `mosi` is ignored during these slots.
  - Outside read data slots, `miso` is 0.
- COMMIT lasts one cycle, then goes to WAIT_CS.
  - For a write, `wr_en_o` is 1 and `wr_cnt_o` increments on the following edge.
  - A data-cache write with address ≥ D_DEPTH is suppressed: `wr_en_o` stays 0, `frame_err_o` pulses, and the count is unchanged.
  - A read in COMMIT issues no write.
- WAIT_CS: go to IDLE on the first cycle where both chip selects are high. Holding a chip select low past the end of a frame never starts a second frame.
- `wr_addr_o`, `wr_data_o` and `wr_tgt_o` are held stable from COMMIT until the next frame starts.

## Timing
- Reset: state IDLE; `wr_en_o`, `frame_err_o`, `busy_o` and `miso` are 0; `wr_cnt_o`, `wr_addr_o`, `wr_data_o`, `rd_addr_o` and `wr_tgt_o` are 0. Reset mid-frame discards the frame without a write or an error pulse.
- If the first bit is sampled at edge E, the last bit is sampled at edge E+FRAME_W-1.
- `wr_en_o` is high during the cycle after that edge. The cache writes at edge E+FRAME_W.
- Minimum frame-to-frame spacing is FRAME_W + 2 cycles: one COMMIT cycle plus at least one WAIT_CS cycle with both chip selects high.
- `busy_o` rises the cycle after the first bit is sampled.
- `rst` has priority over all inputs. `proc_en` has priority over frame start in the same cycle.

## Test plan
- Write, instruction cache: `cs_i_n` low for 13 cycles with `mosi` = 0, 0x3, 0xA5 → one `wr_en_o` pulse, `wr_tgt_o`=0, `wr_addr_o`=3, `wr_data_o`=0xA5, `wr_cnt_o` goes from 0 to 1.
- Data-cache range check: write 0x7E to address 14 → committed. Write to address 15 → no `wr_en_o`, one `frame_err_o` pulse, `wr_cnt_o` unchanged.
- Readback: with `rd_data_i`=0xC3 for address 5, send a read to address 5 on `cs_d_n` → `miso` shows 1,1,0,0,0,0,1,1 in data slots 0..7, and no write occurs.
- Abort: `cs_d_n` rises after 6 bits → one `frame_err_o` pulse, no write, return to IDLE after `cs_d_n` is high. A `proc_en` rise at bit 9 → same behaviour.
- Both chip selects low in IDLE → `frame_err_o` pulse, no shifting until both are high. Chip select held low 5 cycles past a completed frame → exactly one write.
- Reset asserted at bit 7 of a write → no `wr_en_o`, all outputs return to their reset values, and the next full frame commits normally. `wr_cnt_o` wraps from 255 to 0 after 256 writes.
